// File: rtl/aes128_iter_core_pkg.sv
// aes128_iter_core_pkg: state encodings, round count and round-constant table shared by the AES core
package aes128_iter_core_pkg;
  typedef logic [127:0] blk_t;
  localparam logic [3:0] NR = 4'd10;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_KEXP  = 3'd1;
  localparam logic [2:0] ST_SUB   = 3'd2;
  localparam logic [2:0] ST_SHIFT = 3'd3;
  localparam logic [2:0] ST_MIX   = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;
  // Bytes follow FIPS order: byte i at [8i+7:8i], column c at [32c+31:32c]
  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction
endpackage

// File: rtl/aes128_iter_core_aes_v1.sv
// aes_v1: combinational AES transform unit; one of key-step/sub/shift/mix per call, inv selects the inverse
module aes_v1
  import aes128_iter_core_pkg::*;
(
  input  blk_t        i_va,
  input  blk_t        i_vb,
  input  logic [31:0] i_a,
  input  logic        i_ark,
  input  logic        i_sub,
  input  logic        i_shift,
  input  logic        i_mix,
  input  logic        i_inv,
  output blk_t        o_vc
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int k = 0; k < 8; k++) begin
      p = b[k] ? p ^ x : p;
      x = xt(x);
    end
    return p;
  endfunction
  // Field inverse as x^254, so the S-box needs no lookup table
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int k = 0; k < 7; k++) begin
      p = gm(p, p);
      r = gm(r, p);
    end
    return r;
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [7:0] isbox(input logic [7:0] s);
    return ginv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction
  blk_t        w_sb, w_sh, w_mx, w_ks;
  logic [31:0] w_t, w_w3;
  always_comb begin
    w_sb = '0;
    w_sh = '0;
    w_mx = '0;
    for (int i = 0; i < 16; i++)
      w_sb[8*i +: 8] = i_inv ? isbox(i_va[8*i +: 8]) : sbox(i_va[8*i +: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        w_sh[8*(r+4*c) +: 8] = i_inv ? i_va[8*(r+4*((c+4-r)%4)) +: 8] : i_va[8*(r+4*((c+r)%4)) +: 8];
        w_mx[8*(4*c+r) +: 8] = i_inv ?
          gm(i_va[8*(4*c+r) +: 8], 8'd14) ^ gm(i_va[8*(4*c+(r+1)%4) +: 8], 8'd11) ^
          gm(i_va[8*(4*c+(r+2)%4) +: 8], 8'd13) ^ gm(i_va[8*(4*c+(r+3)%4) +: 8], 8'd9) :
          xt(i_va[8*(4*c+r) +: 8]) ^ xt(i_va[8*(4*c+(r+1)%4) +: 8]) ^ i_va[8*(4*c+(r+1)%4) +: 8] ^
          i_va[8*(4*c+(r+2)%4) +: 8] ^ i_va[8*(4*c+(r+3)%4) +: 8];
      end
  end
  // RotWord then SubWord on the last key column, round constant in byte 0
  assign w_w3 = i_vb[127:96];
  assign w_t = {sbox(w_w3[7:0]), sbox(w_w3[31:24]), sbox(w_w3[23:16]), sbox(w_w3[15:8])} ^ i_a;
  assign w_ks[31:0]   = i_vb[31:0] ^ w_t;
  assign w_ks[63:32]  = i_vb[63:32] ^ w_ks[31:0];
  assign w_ks[95:64]  = i_vb[95:64] ^ w_ks[63:32];
  assign w_ks[127:96] = i_vb[127:96] ^ w_ks[95:64];
  assign o_vc = i_ark ? w_ks : i_sub ? w_sb : i_shift ? w_sh : i_mix ? w_mx : '0;
endmodule

// File: rtl/aes128_iter_core.sv
// aes128_iter_core: iterative AES-128 encrypt/decrypt, one transform per clock through aes_v1
module aes128_iter_core
  import aes128_iter_core_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   key_load,
  input  blk_t   key,
  output logic   key_ready,
  input  logic   in_valid,
  output logic   in_ready,
  input  logic   in_dec,
  input  blk_t   in_data,
  output logic   out_valid,
  input  logic   out_ready,
  output blk_t   out_data
);
  logic [2:0] r_state;
  logic [3:0] r_rnd;
  logic       r_dec, r_kr;
  blk_t       r_s;
  blk_t       r_rk [0:10];
  logic       w_ark, w_sub, w_shift, w_mix, w_inv;
  blk_t       w_vc, w_rk, w_vb;
  assign w_ark     = r_state == ST_KEXP;
  assign w_sub     = r_state == ST_SUB;
  assign w_shift   = r_state == ST_SHIFT;
  assign w_mix     = r_state == ST_MIX;
  assign w_inv     = r_dec & (w_sub | w_shift | w_mix);
  assign w_rk      = r_rk[r_rnd];
  assign w_vb      = w_ark ? r_rk[r_rnd - 4'd1] : '0;
  assign key_ready = r_kr;
  assign in_ready  = r_kr & ~key_load & (r_state == ST_IDLE);
  assign out_valid = r_state == ST_DONE;
  assign out_data  = out_valid ? r_s : '0;
  aes_v1 u_aes (
    .i_va(r_s), .i_vb(w_vb), .i_a({24'h0, rcon(r_rnd)}),
    .i_ark(w_ark), .i_sub(w_sub), .i_shift(w_shift), .i_mix(w_mix), .i_inv(w_inv),
    .o_vc(w_vc)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_rnd   <= '0;
      r_dec   <= 1'b0;
      r_kr    <= 1'b0;
      r_s     <= '0;
      for (int i = 0; i < 11; i++) r_rk[i] <= '0;
    end else begin
      case (r_state)
        ST_IDLE:
          if (key_load) begin
            r_rk[0] <= key;
            r_kr    <= 1'b0;
            r_rnd   <= 4'd1;
            r_state <= ST_KEXP;
          end else if (in_valid && r_kr) begin
            r_dec   <= in_dec;
            r_s     <= in_data ^ (in_dec ? r_rk[10] : r_rk[0]);
            r_rnd   <= in_dec ? 4'd9 : 4'd1;
            r_state <= in_dec ? ST_SHIFT : ST_SUB;
          end
        ST_KEXP: begin
          r_rk[r_rnd] <= w_vc;
          r_rnd       <= r_rnd + 4'd1;
          if (r_rnd == NR) begin
            r_kr    <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        ST_SUB: begin
          r_s     <= r_dec ? w_vc ^ w_rk : w_vc;
          r_state <= r_dec ? (r_rnd == 4'd0 ? ST_DONE : ST_MIX) : ST_SHIFT;
        end
        ST_SHIFT: begin
          r_s     <= (!r_dec && r_rnd == NR) ? w_vc ^ r_rk[10] : w_vc;
          r_state <= r_dec ? ST_SUB : (r_rnd == NR ? ST_DONE : ST_MIX);
        end
        ST_MIX: begin
          r_s     <= r_dec ? w_vc : w_vc ^ w_rk;
          r_rnd   <= r_dec ? r_rnd - 4'd1 : r_rnd + 4'd1;
          r_state <= r_dec ? ST_SHIFT : ST_SUB;
        end
        ST_DONE:
          if (out_ready) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes128_iter_core.sv
// tb_aes128_iter_core: scoreboard bench for the iterative AES-128 core using FIPS-197 C.1 vectors
module tb_aes128_iter_core;
  localparam logic [127:0] KEY  = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] PT   = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] CT   = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
  localparam logic [127:0] RK10 = 128'hc5302b4d8ba707f3174a94e37f1d1113;
  logic         clk = 1'b0, rst = 1'b1;
  logic         key_load = 1'b0, in_valid = 1'b0, in_dec = 1'b0, out_ready = 1'b0;
  logic [127:0] key = '0, in_data = '0;
  logic         key_ready, in_ready, out_valid;
  logic [127:0] out_data;
  logic [127:0] q[$];
  int           n_chk = 0, n_err = 0, cnt = 0;
  aes128_iter_core dut (
    .clk(clk), .rst(rst), .key_load(key_load), .key(key), .key_ready(key_ready),
    .in_valid(in_valid), .in_ready(in_ready), .in_dec(in_dec), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic kload(input logic [127:0] k);
    key = k;
    key_load = 1'b1;
    step();
    key_load = 1'b0;
    cnt = 1;
    while (!key_ready && cnt < 100) begin
      step();
      cnt++;
    end
    chk("key_ready_latency", 128'(cnt), 128'd11);
  endtask
  task automatic send(input logic dec, input logic [127:0] d, input logic [127:0] exp);
    in_valid = 1'b1;
    in_dec = dec;
    in_data = d;
    #1;
    chk("in_ready_accept", 128'(in_ready), 128'd1);
    q.push_back(exp);
    step();
    in_valid = 1'b0;
    cnt = 1;
  endtask
  task automatic wait_out();
    while (!out_valid && cnt < 100) begin
      step();
      cnt++;
    end
    chk("block_latency", 128'(cnt), 128'd30);
  endtask
  task automatic take();
    chk("out_data", out_data, q.size() > 0 ? q.pop_front() : 128'hx);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("out_valid_after_take", 128'(out_valid), 128'd0);
    chk("in_ready_after_take", 128'(in_ready), 128'd1);
  endtask
  initial begin
    step();
    chk("rst_key_ready", 128'(key_ready), 128'd0);
    chk("rst_in_ready", 128'(in_ready), 128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    rst = 1'b0;
    step();
    in_valid = 1'b1;
    in_data = PT;
    repeat (5) step();
    chk("no_key_in_ready", 128'(in_ready), 128'd0);
    chk("no_key_out_valid", 128'(out_valid), 128'd0);
    in_valid = 1'b0;
    kload(KEY);
    chk("rk10", dut.r_rk[10], RK10);
    send(1'b0, PT, CT);
    wait_out();
    take();
    send(1'b1, CT, PT);
    wait_out();
    take();
    send(1'b0, PT, CT);
    wait_out();
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", 128'(out_valid), 128'd1);
      chk("bp_out_data", out_data, CT);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
      step();
    end
    take();
    send(1'b1, CT, PT);
    repeat (4) begin
      step();
      cnt++;
    end
    key = '0;
    key_load = 1'b1;
    step();
    cnt++;
    key_load = 1'b0;
    key = KEY;
    wait_out();
    chk("kload_mid_key_ready", 128'(key_ready), 128'd1);
    take();
    key = KEY;
    key_load = 1'b1;
    in_valid = 1'b1;
    in_dec = 1'b0;
    in_data = PT;
    #1;
    chk("kl_vs_iv_in_ready", 128'(in_ready), 128'd0);
    step();
    key_load = 1'b0;
    in_valid = 1'b0;
    chk("kl_vs_iv_key_ready", 128'(key_ready), 128'd0);
    cnt = 1;
    while (!key_ready && cnt < 100) begin
      step();
      cnt++;
    end
    chk("kl_vs_iv_latency", 128'(cnt), 128'd11);
    repeat (3) step();
    chk("kl_vs_iv_no_out", 128'(out_valid), 128'd0);
    send(1'b0, PT, CT);
    repeat (11) step();
    rst = 1'b1;
    step();
    void'(q.pop_back());
    chk("mid_rst_out_valid", 128'(out_valid), 128'd0);
    chk("mid_rst_out_data", out_data, 128'd0);
    chk("mid_rst_key_ready", 128'(key_ready), 128'd0);
    chk("mid_rst_in_ready", 128'(in_ready), 128'd0);
    chk("mid_rst_rk10", dut.r_rk[10], 128'd0);
    rst = 1'b0;
    step();
    kload(KEY);
    send(1'b0, PT, CT);
    wait_out();
    take();
    chk("scoreboard_empty", 128'(q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
